// File: rtl/blackjack_round_sequencer.sv
// Blackjack round controller: deals, runs the player and dealer turns, resolves the round
// and is the single requester of the shared card source (req/valid handshake).
module blackjack_round_sequencer #(
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_hit,
    input  logic       btn_stand,
    input  logic       btn_double,
    output logic       card_req,
    input  logic       card_valid,
    input  logic [3:0] card_value,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [2:0] player_cards,
    output logic [2:0] dealer_cards,
    output logic       dealer_reveal,
    output logic       bet_doubled,
    output logic [2:0] result,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_CHECK_BJ,
        S_PLAYER_TURN, S_P_DRAW, S_DEALER_TURN, S_D_DRAW, S_RESOLVE, S_DONE
    } state_t;

    localparam logic [4:0] STAND_TOTAL = 5'(DEALER_STAND);
    localparam logic [2:0] CARD_CAP    = 3'(MAX_CARDS);
    localparam logic [2:0] RES_NONE = 3'd0;
    localparam logic [2:0] RES_BJ   = 3'd1;
    localparam logic [2:0] RES_WIN  = 3'd2;
    localparam logic [2:0] RES_LOSE = 3'd3;
    localparam logic [2:0] RES_PUSH = 3'd4;

    state_t     state, state_next;
    logic       start_q, hit_q, stand_q, double_q;
    logic       start_edge, hit_edge, stand_edge, double_edge;
    logic [4:0] p_hard, d_hard;
    logic       p_ace, d_ace;
    logic [3:0] d1_rank;
    logic [3:0] card_rank;
    logic [4:0] p_eff, d_eff, d1_eff;
    logic       take, in_draw, round_start, double_go;
    logic [2:0] res_calc;

    // An ace counts 11 whenever that does not bust the hand.
    function automatic logic [4:0] eff_total(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [3:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {2'b00, b};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    assign start_edge  = btn_start  & ~start_q;
    assign hit_edge    = btn_hit    & ~hit_q;
    assign stand_edge  = btn_stand  & ~stand_q;
    assign double_edge = btn_double & ~double_q;

    assign card_rank = (card_value == 4'd0 || card_value > 4'd10) ? 4'd10 : card_value;
    assign take      = card_req & card_valid;
    assign in_draw   = state inside {S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_P_DRAW, S_D_DRAW};
    assign round_start = (state == S_IDLE || state == S_DONE) && start_edge;

    assign p_eff  = eff_total(p_hard, p_ace);
    assign d_eff  = eff_total(d_hard, d_ace);
    assign d1_eff = eff_total({1'b0, d1_rank}, d1_rank == 4'd1);

    assign player_total = p_eff;
    assign dealer_total = dealer_reveal ? d_eff : d1_eff;
    assign busy         = !(state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_next = state;
        double_go  = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: if (start_edge) state_next = S_DEAL_P1;
            S_DEAL_P1:      if (take) state_next = S_DEAL_D1;
            S_DEAL_D1:      if (take) state_next = S_DEAL_P2;
            S_DEAL_P2:      if (take) state_next = S_DEAL_D2;
            S_DEAL_D2:      if (take) state_next = S_CHECK_BJ;
            S_CHECK_BJ:     state_next = (p_eff == 5'd21) ? S_RESOLVE : S_PLAYER_TURN;
            S_PLAYER_TURN: begin
                // Hand status is settled before any button is honoured.
                if (p_eff > 5'd21)
                    state_next = S_RESOLVE;
                else if (p_eff == 5'd21 || player_cards == CARD_CAP || bet_doubled)
                    state_next = S_DEALER_TURN;
                else if (stand_edge)
                    state_next = S_DEALER_TURN;
                else if (double_edge && player_cards == 3'd2) begin
                    state_next = S_P_DRAW;
                    double_go  = 1'b1;
                end else if (hit_edge)
                    state_next = S_P_DRAW;
            end
            S_P_DRAW:       if (take) state_next = S_PLAYER_TURN;
            S_DEALER_TURN:  state_next = (d_eff < STAND_TOTAL && dealer_cards < CARD_CAP)
                                         ? S_D_DRAW : S_RESOLVE;
            S_D_DRAW:       if (take) state_next = S_DEALER_TURN;
            S_RESOLVE:      state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        res_calc = RES_PUSH;
        if (player_cards == 3'd2 && p_eff == 5'd21)
            res_calc = (d_eff == 5'd21) ? RES_PUSH : RES_BJ;
        else if (p_eff > 5'd21)  res_calc = RES_LOSE;
        else if (d_eff > 5'd21)  res_calc = RES_WIN;
        else if (p_eff > d_eff)  res_calc = RES_WIN;
        else if (p_eff < d_eff)  res_calc = RES_LOSE;
    end

    // NOTE: all registered state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q       <= 1'b0;
            hit_q         <= 1'b0;
            stand_q       <= 1'b0;
            double_q      <= 1'b0;
            card_req      <= 1'b0;
            p_hard        <= '0;
            p_ace         <= 1'b0;
            player_cards  <= '0;
            d_hard        <= '0;
            d_ace         <= 1'b0;
            dealer_cards  <= '0;
            d1_rank       <= '0;
            dealer_reveal <= 1'b0;
            bet_doubled   <= 1'b0;
            result        <= RES_NONE;
        end else begin
            start_q  <= btn_start;
            hit_q    <= btn_hit;
            stand_q  <= btn_stand;
            double_q <= btn_double;
            // Request rises one cycle into a draw state and drops right after the card is taken.
            card_req <= in_draw && !take;

            if (round_start) begin
                p_hard        <= '0;
                p_ace         <= 1'b0;
                player_cards  <= '0;
                d_hard        <= '0;
                d_ace         <= 1'b0;
                dealer_cards  <= '0;
                d1_rank       <= '0;
                dealer_reveal <= 1'b0;
                bet_doubled   <= 1'b0;
                result        <= RES_NONE;
            end

            if (take) begin
                unique case (state)
                    S_DEAL_P1, S_DEAL_P2, S_P_DRAW: begin
                        p_hard       <= sat_add(p_hard, card_rank);
                        p_ace        <= p_ace | (card_rank == 4'd1);
                        player_cards <= player_cards + 3'd1;
                    end
                    S_DEAL_D1, S_DEAL_D2, S_D_DRAW: begin
                        d_hard       <= sat_add(d_hard, card_rank);
                        d_ace        <= d_ace | (card_rank == 4'd1);
                        dealer_cards <= dealer_cards + 3'd1;
                        if (state == S_DEAL_D1) d1_rank <= card_rank;
                    end
                    default: ;
                endcase
            end

            if (state_next == S_DEALER_TURN || (state == S_CHECK_BJ && state_next == S_RESOLVE))
                dealer_reveal <= 1'b1;
            if (double_go)
                bet_doubled <= 1'b1;
            if (state == S_RESOLVE)
                result <= res_calc;
        end
    end

endmodule
